hw_sw_mailbox: RTL and testbench
================================

# hw_sw_mailbox

Parametrised, double-buffered mailbox between the NIOS PIO ports and the drawing hardware. Software writes a full set of port words and raises a request on the 2-bit signal lines. The block snapshots the set into a staging bank and acknowledges. The staged set is then committed to the hardware-facing bank at the next frame start, so the renderer never sees a half-updated set. It supersedes the fixed 16-port, handshake-only comm block in the top level.

## Interface
Parameters:
- NUM_PORTS, 16, number of software-to-hardware words (1..32)
- DATA_W, 32, width of each word in bits
- CNT_W, 8, width of the overrun counter

Ports:
- Clk  in  1  system clock (50 MHz, same domain as NIOS PIOs)
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  single-cycle pulse at start of vertical blanking
- to_hw_sig  in  2  software command: 00 idle, 01 request (frame-synced), 10 request-immediate, 11 cancel
- to_sw_sig  out  2  status to software: [0] ack, [1] pending (staged set not yet committed)
- sw_ports  in  NUM_PORTS*DATA_W  flattened software words; port k at [k*DATA_W +: DATA_W]
- hw_ports  out  NUM_PORTS*DATA_W  committed words seen by hardware, same packing
- commit_pulse  out  1  one-cycle pulse the cycle after hw_ports changes
- overrun_cnt  out  CNT_W  saturating count of captures that overwrote an uncommitted set

## Operation
- The state machine has two states: IDLE and ACK.
- IDLE with to_hw_sig = 00: no action.
- IDLE with 01: staged <= sw_ports; pending <= 1; go to ACK. If pending was already 1, overrun_cnt increments (saturating at all-ones) and the newer set wins.
- IDLE with 10: staged <= sw_ports and hw_ports <= sw_ports; pending <= 0; commit_pulse next cycle; go to ACK. Overrun is not counted.
- IDLE with 11: pending <= 0 (staged set discarded; hw_ports unchanged); go to ACK.
- ACK: ack = 1. The block stays in ACK while to_hw_sig != 00. When to_hw_sig = 00, ack drops and the state returns to IDLE. Commands seen in ACK are ignored; a command takes effect only on an IDLE edge.
- Commit: when pending = 1 and frame_start = 1, hw_ports <= staged, pending <= 0, and commit_pulse is 1 on the following cycle. Commit is evaluated independently of the FSM state.
- Capture (01) and commit on the same edge:
  - the commit uses the old staged set;
  - the new capture leaves pending = 1;
  - overrun is not counted, because the old set was consumed.
- Cancel (11) and commit on the same edge: cancel wins, and no commit occurs.
- frame_start with pending = 0 has no effect.

## Timing
- Reset values: hw_ports 0, staged 0, to_sw_sig 00, commit_pulse 0, overrun_cnt 0, state IDLE.
- Reset mid-handshake forces ack to 0. Software must re-issue the request after it sees ack = 0.
- to_hw_sig is sampled on the rising edge of Clk. ack and pending are registered and become visible 1 cycle after the sampling edge.
- Capture latency is 1 edge. Frame-synced commit happens at the first frame_start edge at or after the cycle when pending is visible. Immediate commit updates hw_ports on the capture edge.
- All outputs are driven directly from registers; there are no combinational paths from inputs to outputs.
- sw_ports must be stable during the cycle in which to_hw_sig first reads 01 or 10.

## Configuration
- MAILBOX_FRAME_SYNC_EN defined: behaviour is exactly as described above.
- MAILBOX_FRAME_SYNC_EN undefined:
  - frame_start is ignored;
  - command 01 behaves identically to 10 (immediate commit);
  - pending is always 0;
  - overrun_cnt stays 0.

## Test plan
- Reset then idle: hw_ports = 0, to_sw_sig = 00, overrun_cnt = 0 for 100 cycles. Assert reset_n low mid-ACK -> ack = 0 immediately.
- sw_ports port3 = 0xDEADBEEF, drive 01 -> next cycle to_sw_sig = 11. hw_ports stays unchanged until frame_start. After frame_start, port3 = 0xDEADBEEF, commit_pulse high exactly 1 cycle, to_sw_sig = 01. Drive 00 -> to_sw_sig = 00.
- Drive 10 with port0 = 0x12345678 -> hw_ports port0 = 0x12345678 on the capture edge, commit_pulse next cycle, pending never set.
- Two 01 handshakes (0x1, then 0x2) with no frame_start between -> overrun_cnt = 1; after frame_start, hw_ports port0 = 0x2. Force 300 overruns -> overrun_cnt = 0xFF.
- 01 with 0xAA, then on the edge where frame_start is high issue 01 with 0xBB -> hw_ports = 0xAA, pending = 1, overrun_cnt unchanged. Next frame_start -> 0xBB.
- Capture 0x55, then 11 on the same edge as frame_start -> hw_ports unchanged, pending = 0, no commit_pulse. Build with MAILBOX_FRAME_SYNC_EN undefined: 01 commits immediately.

Source files
------------

// File: rtl/hw_sw_mailbox.sv
// rtl/hw_sw_mailbox.sv - double-buffered software-to-hardware port mailbox with frame-synced commit
// Optional feature macro: MAILBOX_FRAME_SYNC_EN (frame-synced staging; undefined => every request commits immediately)
module hw_sw_mailbox #(
  parameter int NUM_PORTS = 16,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 8
) (
  input  logic                        Clk,
  input  logic                        reset_n,
  input  logic                        frame_start,
  input  logic [1:0]                  to_hw_sig,
  output logic [1:0]                  to_sw_sig,
  input  logic [NUM_PORTS*DATA_W-1:0] sw_ports,
  output logic [NUM_PORTS*DATA_W-1:0] hw_ports,
  output logic                        commit_pulse,
  output logic [CNT_W-1:0]            overrun_cnt
);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t                      state, state_nxt;
  logic [NUM_PORTS*DATA_W-1:0] staged;
  logic                        pending;
  logic                        ack;
  logic                        do_capture;
  logic                        do_immediate;
  logic                        do_cancel;
  logic                        do_commit;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (to_hw_sig != 2'b00) state_nxt = ACK;
      ACK:     if (to_hw_sig == 2'b00) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Commands are decoded only in IDLE; anything held during ACK is ignored.
  always_comb begin
    ack          = (state == ACK);
    do_capture   = 1'b0;
    do_immediate = 1'b0;
    do_cancel    = 1'b0;
    if (state == IDLE) begin
      case (to_hw_sig)
`ifdef MAILBOX_FRAME_SYNC_EN
        2'b01:   do_capture   = 1'b1;
`else
        2'b01:   do_immediate = 1'b1;
`endif
        2'b10:   do_immediate = 1'b1;
        2'b11:   do_cancel    = 1'b1;
        default: ;
      endcase
    end
  end

  // A cancel on the frame edge discards the staged set before it can commit.
  assign do_commit = pending && frame_start && !do_cancel;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      staged       <= '0;
      hw_ports     <= '0;
      pending      <= 1'b0;
      commit_pulse <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      commit_pulse <= 1'b0;
      if (do_immediate) begin
        staged       <= sw_ports;
        hw_ports     <= sw_ports;
        pending      <= 1'b0;
        commit_pulse <= 1'b1;
      end else begin
        if (do_commit) begin
          hw_ports     <= staged;
          commit_pulse <= 1'b1;
        end
        if (do_capture) begin
          staged  <= sw_ports;
          pending <= 1'b1;
          // Only a set that is still uncommitted after this edge counts as lost.
          if (pending && !do_commit && (overrun_cnt != {CNT_W{1'b1}}))
            overrun_cnt <= overrun_cnt + CNT_W'(1);
        end else if (do_cancel || do_commit) begin
          pending <= 1'b0;
        end
      end
    end
  end

  assign to_sw_sig = {pending, ack};

endmodule

// File: tb/tb_hw_sw_mailbox.sv
// tb/tb_hw_sw_mailbox.sv - self-checking bench for hw_sw_mailbox (reference model plus directed vectors)
module tb_hw_sw_mailbox;
  localparam int NUM_PORTS = 16;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef MAILBOX_FRAME_SYNC_EN
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif

  logic                        Clk;
  logic                        reset_n;
  logic                        frame_start;
  logic [1:0]                  to_hw_sig;
  logic [1:0]                  to_sw_sig;
  logic [NUM_PORTS*DATA_W-1:0] sw_ports;
  logic [NUM_PORTS*DATA_W-1:0] hw_ports;
  logic                        commit_pulse;
  logic [CNT_W-1:0]            overrun_cnt;

  logic [DATA_W-1:0] sw [NUM_PORTS];

  int n_checks = 0;
  int n_fails  = 0;
  bit model_on = 1'b0;

  hw_sw_mailbox #(.NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .reset_n(reset_n), .frame_start(frame_start), .to_hw_sig(to_hw_sig),
    .to_sw_sig(to_sw_sig), .sw_ports(sw_ports), .hw_ports(hw_ports),
    .commit_pulse(commit_pulse), .overrun_cnt(overrun_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always_comb begin
    sw_ports = '0;
    for (int k = 0; k < NUM_PORTS; k++) sw_ports[k*DATA_W +: DATA_W] = sw[k];
  end

  // Reference model: software-visible meaning of the mailbox, one update per clock.
  logic [DATA_W-1:0] m_hw     [NUM_PORTS];
  logic [DATA_W-1:0] m_staged [NUM_PORTS];
  bit                m_busy, m_pending, m_pulse;
  int                m_overruns;

  always @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_PORTS; k++) begin m_hw[k] = '0; m_staged[k] = '0; end
      m_busy = 0; m_pending = 0; m_pulse = 0; m_overruns = 0;
    end else begin
      bit issued, committed, had_set;
      issued    = !m_busy && (to_hw_sig != 2'b00);
      had_set   = m_pending;
      committed = FS && m_pending && frame_start && !(issued && to_hw_sig == 2'b11);
      m_pulse   = 0;
      if (committed) begin
        for (int k = 0; k < NUM_PORTS; k++) m_hw[k] = m_staged[k];
        m_pending = 0;
        m_pulse   = 1;
      end
      if (issued) begin
        if (to_hw_sig == 2'b11) begin
          m_pending = 0;
        end else if (to_hw_sig == 2'b01 && FS) begin
          if (had_set && !committed && m_overruns < CNT_MAX) m_overruns++;
          for (int k = 0; k < NUM_PORTS; k++) m_staged[k] = sw[k];
          m_pending = 1;
        end else begin
          for (int k = 0; k < NUM_PORTS; k++) begin m_staged[k] = sw[k]; m_hw[k] = sw[k]; end
          m_pending = 0;
          m_pulse   = 1;
        end
        m_busy = 1;
      end else if (to_hw_sig == 2'b00) begin
        m_busy = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (model_on && reset_n) begin
      logic [NUM_PORTS*DATA_W-1:0] exp_hw;
      for (int k = 0; k < NUM_PORTS; k++) exp_hw[k*DATA_W +: DATA_W] = m_hw[k];
      n_checks++;
      if (hw_ports !== exp_hw) begin
        n_fails++;
        $display("FAIL model_hw_ports: actual=%h required=%h", hw_ports, exp_hw);
      end
      chk("model_to_sw_sig", 64'(to_sw_sig), 64'({m_pending, m_busy}));
      chk("model_commit_pulse", 64'(commit_pulse), 64'(m_pulse));
      chk("model_overrun_cnt", 64'(overrun_cnt), 64'(m_overruns));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic hs(input logic [1:0] cmd);
    to_hw_sig = cmd;
    cyc(1);
    to_hw_sig = 2'b00;
    cyc(1);
  endtask

  task automatic frame;
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] port(input int k);
    return hw_ports[k*DATA_W +: DATA_W];
  endfunction

  int ovr_before;

  initial begin
    reset_n = 1'b0; frame_start = 1'b0; to_hw_sig = 2'b00;
    for (int k = 0; k < NUM_PORTS; k++) sw[k] = '0;
    cyc(2);
    chk("reset_to_sw_sig", 64'(to_sw_sig), 64'd0);
    chk("reset_commit_pulse", 64'(commit_pulse), 64'd0);
    reset_n = 1'b1;
    model_on = 1'b1;
    cyc(100);
    chk("idle_hw_ports", 64'(hw_ports == '0), 64'd1);
    chk("idle_to_sw_sig", 64'(to_sw_sig), 64'd0);
    chk("idle_overrun", 64'(overrun_cnt), 64'd0);

    // Reset asserted while ACK is showing must clear ack without waiting for a clock.
    sw[1] = 32'hCAFE0001;
    to_hw_sig = 2'b01;
    cyc(1);
    chk("ack_before_reset", 64'(to_sw_sig[0]), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("ack_async_reset", 64'(to_sw_sig), 64'd0);
    chk("hw_async_reset", 64'(hw_ports == '0), 64'd1);
    to_hw_sig = 2'b00;
    cyc(1);
    reset_n = 1'b1;
    cyc(1);

    // Frame-synced request.
    sw[3] = 32'hDEADBEEF;
    to_hw_sig = 2'b01;
    cyc(1);
    chk("req_to_sw_sig", 64'(to_sw_sig), FS ? 64'd3 : 64'd1);
    chk("req_port3_before_frame", 64'(port(3)), FS ? 64'd0 : 64'hDEADBEEF);
    cyc(2);
    chk("req_port3_held", 64'(port(3)), FS ? 64'd0 : 64'hDEADBEEF);
    frame;
    chk("frame_port3", 64'(port(3)), 64'hDEADBEEF);
    chk("frame_commit_pulse", 64'(commit_pulse), FS ? 64'd1 : 64'd0);
    chk("frame_to_sw_sig", 64'(to_sw_sig), 64'd1);
    cyc(1);
    chk("frame_pulse_one_cycle", 64'(commit_pulse), 64'd0);
    to_hw_sig = 2'b00;
    cyc(1);
    chk("release_to_sw_sig", 64'(to_sw_sig), 64'd0);

    // Immediate request.
    sw[0] = 32'h12345678;
    to_hw_sig = 2'b10;
    cyc(1);
    chk("imm_port0", 64'(port(0)), 64'h12345678);
    chk("imm_commit_pulse", 64'(commit_pulse), 64'd1);
    chk("imm_no_pending", 64'(to_sw_sig), 64'd1);
    to_hw_sig = 2'b00;
    cyc(1);
    chk("imm_pulse_end", 64'(commit_pulse), 64'd0);

    // Overrun counting and saturation.
    sw[0] = 32'h1; hs(2'b01);
    sw[0] = 32'h2; hs(2'b01);
    chk("overrun_one", 64'(overrun_cnt), FS ? 64'd1 : 64'd0);
    frame;
    chk("overrun_newer_wins", 64'(port(0)), 64'h2);
    for (int i = 0; i < 300; i++) begin
      sw[0] = 32'(i); hs(2'b01);
    end
    chk("overrun_saturated", 64'(overrun_cnt), FS ? 64'hFF : 64'd0);
    frame;
    cyc(1);

    // Capture on the same edge as a commit of the previous set.
    sw[0] = 32'hAA; hs(2'b01);
    ovr_before = int'(overrun_cnt);
    sw[0] = 32'hBB; to_hw_sig = 2'b01; frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    chk("coincide_port0", 64'(port(0)), FS ? 64'hAA : 64'hBB);
    chk("coincide_pending", 64'(to_sw_sig), FS ? 64'd3 : 64'd1);
    chk("coincide_overrun", 64'(overrun_cnt), 64'(ovr_before));
    to_hw_sig = 2'b00;
    cyc(1);
    frame;
    chk("coincide_next_frame", 64'(port(0)), 64'hBB);
    cyc(1);

    // Cancel on the frame edge beats the commit.
    sw[0] = 32'h55; hs(2'b01);
    to_hw_sig = 2'b11; frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    chk("cancel_port0", 64'(port(0)), FS ? 64'hBB : 64'h55);
    chk("cancel_no_pulse", 64'(commit_pulse), 64'd0);
    chk("cancel_pending", 64'(to_sw_sig), 64'd1);
    to_hw_sig = 2'b00;
    cyc(1);
    frame;
    chk("cancel_frame_no_effect", 64'(port(0)), FS ? 64'hBB : 64'h55);
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
